// File: rtl/adsr_envelope_generator.sv
// Per-voice ADSR envelope: a 24-bit accumulator stepped once per audio tick.
// The top 16 bits of the accumulator drive the voice mixer amplitude.
module adsr_envelope_generator #(
  parameter int unsigned PERCENT_WIDTH          = 7,
  parameter int unsigned ENVELOPE_COUNTER_WIDTH = 16,
  parameter int unsigned ENVELOPE_PUSH_BITS     = 8,
  parameter int unsigned STEP_SHIFT             = 8
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              tick_i,
  input  logic                              note_on_i,
  input  logic                              note_off_i,
  input  logic [PERCENT_WIDTH-1:0]          attack_i,
  input  logic [PERCENT_WIDTH-1:0]          decay_i,
  input  logic [PERCENT_WIDTH-1:0]          sustain_i,
  input  logic [PERCENT_WIDTH-1:0]          release_i,
  output logic [ENVELOPE_COUNTER_WIDTH-1:0] level_o,
  output logic                              active_o
);

  localparam int unsigned ACC_W = ENVELOPE_COUNTER_WIDTH + ENVELOPE_PUSH_BITS;
  localparam int unsigned REP_W = 3 * PERCENT_WIDTH;

  localparam logic [ACC_W-1:0]         ACC_FULL = '1;
  localparam logic [ACC_W-1:0]         ACC_ZERO = '0;
  localparam logic [PERCENT_WIDTH-1:0] P_ZERO   = '0;
  localparam logic [PERCENT_WIDTH:0]   RATE_MAX = (PERCENT_WIDTH + 1)'(1) << PERCENT_WIDTH;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             active_q, active_d;

  // Larger rate value means a slower ramp: step = (2^P - p) << STEP_SHIFT.
  function automatic logic [ACC_W-1:0] rate_step(input logic [PERCENT_WIDTH-1:0] p);
    logic [PERCENT_WIDTH:0] inv;
    inv = RATE_MAX - {1'b0, p};
    return ACC_W'(inv) << STEP_SHIFT;
  endfunction

  logic [ACC_W-1:0]                  step_a, step_d, step_r;
  logic [REP_W-1:0]                  sus_rep;
  logic [ENVELOPE_COUNTER_WIDTH-1:0] sus_lvl;
  logic [ACC_W-1:0]                  sus_acc;
  logic [ACC_W:0]                    att_sum, dec_diff, rel_diff;

  assign step_a  = rate_step(attack_i);
  assign step_d  = rate_step(decay_i);
  assign step_r  = rate_step(release_i);

  // Replicating the 7-bit sustain fills the 16-bit range so 127 maps to full scale.
  assign sus_rep = {sustain_i, sustain_i, sustain_i};
  assign sus_lvl = sus_rep[REP_W-1 -: ENVELOPE_COUNTER_WIDTH];
  assign sus_acc = {sus_lvl, {ENVELOPE_PUSH_BITS{1'b0}}};

  // One extra bit exposes carry/borrow so every ramp saturates instead of wrapping.
  assign att_sum  = {1'b0, acc_q} + {1'b0, step_a};
  assign dec_diff = {1'b0, acc_q} - {1'b0, step_d};
  assign rel_diff = {1'b0, acc_q} - {1'b0, step_r};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (note_on_i) begin
      // Legato retrigger: accumulator is kept, only the phase restarts.
      state_d = ST_ATTACK;
    end else if (note_off_i) begin
      if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
        state_d = ST_RELEASE;
      end
    end else if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          acc_d = ACC_ZERO;
        end
        ST_ATTACK: begin
          if (attack_i == P_ZERO || att_sum[ACC_W] || att_sum[ACC_W-1:0] == ACC_FULL) begin
            acc_d   = ACC_FULL;
            state_d = ST_DECAY;
          end else begin
            acc_d = att_sum[ACC_W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_i == P_ZERO || dec_diff[ACC_W] ||
              dec_diff[ACC_W-1 -: ENVELOPE_COUNTER_WIDTH] <= sus_lvl) begin
            acc_d   = sus_acc;
            state_d = ST_SUSTAIN;
          end else begin
            acc_d = dec_diff[ACC_W-1:0];
          end
        end
        ST_SUSTAIN: begin
          acc_d = sus_acc;
        end
        ST_RELEASE: begin
          if (release_i == P_ZERO || rel_diff[ACC_W] || rel_diff[ACC_W-1:0] == ACC_ZERO) begin
            acc_d   = ACC_ZERO;
            state_d = ST_IDLE;
          end else begin
            acc_d = rel_diff[ACC_W-1:0];
          end
        end
        default: begin
          acc_d   = ACC_ZERO;
          state_d = ST_IDLE;
        end
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= ACC_ZERO;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      active_q <= active_d;
    end
  end

  assign level_o  = acc_q[ACC_W-1 -: ENVELOPE_COUNTER_WIDTH];
  assign active_o = active_q;

endmodule

// File: doc/adsr_envelope_generator.md
Name: adsr_envelope_generator

Overview:
- Per-voice ADSR envelope stage. Sits between the MIDI/voice-allocation front end and the oscillator amplitude multiplier.
- Takes note_on/note_off events and four 7-bit percent_t parameters (attack, decay, sustain, release).
- Advances once per audio-generation tick (AUDIO_GENERATION_FREQUENCY, 50 kHz strobe).
- Outputs a 16-bit amplitude level consumed by the voice mixer.

Parameters:
- PERCENT_WIDTH, 7, width of the A/D/S/R parameter inputs (percent_t).
- ENVELOPE_COUNTER_WIDTH, 16, width of the output level.
- ENVELOPE_PUSH_BITS, 8, fractional bits below the level. Accumulator width ACC_W = 16+8 = 24.
- STEP_SHIFT, 8, left shift applied to the rate value to form the per-tick step.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle strobe at 50 kHz; the envelope advances only on tick.
- note_on  in  1  one-cycle pulse, key pressed.
- note_off  in  1  one-cycle pulse, key released.
- attack  in  7  attack rate parameter; 0 = instant, 127 = slowest.
- decay  in  7  decay rate parameter; same encoding as attack.
- sustain  in  7  sustain level parameter; 0 = silent, 127 = full.
- release  in  7  release rate parameter; same encoding as attack.
- level  out  16  envelope amplitude, acc[23:8].
- active  out  1  1 when state != IDLE.

Behaviour:
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. 24-bit accumulator acc. level = acc[23:8], registered.
- Reset: state=IDLE, acc=0, level=0x0000, active=0. Reset overrides tick and events in the same cycle.
- Step for rate p: p=0 means instant. p>0 gives step = (128-p) << STEP_SHIFT (24-bit).
  - p=127 gives step 0x000100.
  - p=1 gives step 0x007F00.
- sus16 = {sustain, sustain, sustain[6:5]}. Examples: 127→0xFFFF, 64→0x8102, 0→0x0000.
- Parameters are sampled live on every tick; there is no latching at note_on.
- Event handling happens on any cycle, independent of tick:
  - note_on in any state → ATTACK. acc is kept (legato retrigger, no reset to zero).
  - note_off in ATTACK/DECAY/SUSTAIN → RELEASE, acc kept.
  - note_off in IDLE/RELEASE → ignored.
  - note_on and note_off in the same cycle: note_on wins, note_off is dropped.
  - A cycle carrying an event performs the state change only; acc is not updated even if tick is also high.
- Tick handling, applied only when there is no event that cycle:
  - IDLE: hold acc=0.
  - ATTACK: acc = min(acc+step_a, 0xFFFFFF). attack=0 gives 0xFFFFFF. On reaching 0xFFFFFF → DECAY in the same update.
  - DECAY: d = acc-step_d, where decay=0 means d=0. If d underflows or d[23:8] <= sus16: acc={sus16,8'h00}, → SUSTAIN. Else acc=d.
  - SUSTAIN: acc={sus16,8'h00} every tick, so a sustain change takes effect on the next tick. No state change.
  - RELEASE: acc = max(acc-step_r, 0). release=0 gives 0. When the result is 0 → IDLE.
- Arithmetic: add and subtract in 25 bits. Carry or borrow saturates as specified above. No wrap-around is ever permitted.
- Latency: level and active reflect an update on the cycle after the tick/event edge (one registered stage).
- Reset mid-operation: returns to IDLE, level=0 on the next cycle. There is no fade.

Test Plan:
- Reset: assert reset for 2 cycles with tick high → level=0x0000, active=0. A note_on during reset is ignored.
- Instant A/D: attack=0, decay=0, sustain=64; note_on, then tick → level=0xFFFF, state DECAY. Next tick → level=0x8102, SUSTAIN, active=1.
- Linear attack: attack=1, from IDLE. The note_on cycle with tick high leaves level at 0. The first tick after that → level=0x007F; after 2 ticks → 0x00FE. Ticks without note events never change IDLE (level stays 0).
- Slow release: sustain at 0x8102 (acc 0x810200), release=127, note_off → level decreases by exactly 1 per tick. Reaches 0x0000 after 33026 ticks; active=0 on the following cycle.
- Simultaneous events: in SUSTAIN, pulse note_on and note_off in the same cycle as tick → state ATTACK, level unchanged that cycle. With attack=0, the next tick → 0xFFFF.
- Saturation/retrigger: attack=127 at level 0xFFF0 → saturates at 0xFFFF, no wrap. note_on during RELEASE at level 0x4000 → attack resumes from 0x4000, not 0.
